syn_vga_fsm: RTL

//  Downstream consumer of the VGA line buffer: generates 640x480@60 VGA timing and pulls
//  one 8-bit pixel per visible pixel slot from the line buffer's FWFT FIFO interface.

---
 rtl/syn_vga_fsm.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/syn_vga_fsm.sv
// VGA timing generator (640x480@60 by default) pulling RGB332 pixels from a FWFT line-buffer FIFO.
// Optional build macro SYN_VGA_FSM_TEST_PATTERN_EN replaces pixel colour with eight vertical bars.
module syn_vga_fsm #(
    parameter int P_PIX_DIV = 2,
    parameter int P_H_VIS   = 640,
    parameter int P_H_FP    = 16,
    parameter int P_H_SYNC  = 96,
    parameter int P_H_BP    = 48,
    parameter int P_V_VIS   = 480,
    parameter int P_V_FP    = 10,
    parameter int P_V_SYNC  = 2,
    parameter int P_V_BP    = 33
) (
    input  logic        clk_ir,
    input  logic        rst_sync_l,
    input  logic        vga_drvr_en,
    input  logic        ff_empty,
    input  logic [7:0]  ff_rd_data,
    output logic        ff_rd_en,
    output logic        vga_hsync_n,
    output logic        vga_vsync_n,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        frame_start,
    output logic [15:0] underflow_cnt
);

    localparam int H_TOT = P_H_VIS + P_H_FP + P_H_SYNC + P_H_BP;
    localparam int V_TOT = P_V_VIS + P_V_FP + P_V_SYNC + P_V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int DW    = (P_PIX_DIV > 1) ? $clog2(P_PIX_DIV) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_VIS_E  = HW'(P_H_VIS);
    localparam logic [HW-1:0] H_SYNC_S = HW'(P_H_VIS + P_H_FP);
    localparam logic [HW-1:0] H_SYNC_E = HW'(P_H_VIS + P_H_FP + P_H_SYNC);
    localparam logic [HW-1:0] H_ONE    = HW'(1'b1);
    localparam logic [HW-1:0] H_ZERO   = {HW{1'b0}};
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_VIS_E  = VW'(P_V_VIS);
    localparam logic [VW-1:0] V_SYNC_S = VW'(P_V_VIS + P_V_FP);
    localparam logic [VW-1:0] V_SYNC_E = VW'(P_V_VIS + P_V_FP + P_V_SYNC);
    localparam logic [VW-1:0] V_ONE    = VW'(1'b1);
    localparam logic [VW-1:0] V_ZERO   = {VW{1'b0}};
    localparam logic [DW-1:0] D_LAST   = DW'(P_PIX_DIV - 1);
    localparam logic [DW-1:0] D_ONE    = DW'(1'b1);
    localparam logic [DW-1:0] D_ZERO   = {DW{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_FILL = 2'd1,
        ST_ACTIVE    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          hsync_n_q, hsync_n_d;
    logic          vsync_n_q, vsync_n_d;
    logic [11:0]   rgb_q, rgb_d;
    logic          frame_start_q, frame_start_d;
    logic [15:0]   underflow_q, underflow_d;

    logic          pix_tick_s;
    logic          visible_s;
    logic          hsync_n_s;
    logic          vsync_n_s;
    logic [11:0]   pix_rgb_s;
    logic          rd_en_s;

`ifdef SYN_VGA_FSM_TEST_PATTERN_EN
    localparam logic [HW-1:0] BAR_W = HW'(P_H_VIS / 8);
    logic [HW-1:0] bar_s;
`endif

    // Pixel-slot decode and colour source from the current counters.
    always_comb begin
        pix_tick_s = (state_q == ST_ACTIVE) && (div_q == D_LAST);
        visible_s  = (h_q < H_VIS_E) && (v_q < V_VIS_E);
        hsync_n_s  = !((h_q >= H_SYNC_S) && (h_q < H_SYNC_E));
        vsync_n_s  = !((v_q >= V_SYNC_S) && (v_q < V_SYNC_E));
`ifdef SYN_VGA_FSM_TEST_PATTERN_EN
        bar_s      = h_q / BAR_W;
        pix_rgb_s  = {{4{bar_s[2]}}, {4{bar_s[1]}}, {4{bar_s[0]}}};
`else
        // RGB332 widened to 4 bits by replicating the top bit(s) of each field.
        pix_rgb_s  = {ff_rd_data[7:5], ff_rd_data[7],
                      ff_rd_data[4:2], ff_rd_data[4],
                      ff_rd_data[1:0], ff_rd_data[1:0]};
`endif
    end

    // Controller FSM, raster counters and next values of the registered pins.
    always_comb begin
        state_d       = state_q;
        div_d         = div_q;
        h_d           = h_q;
        v_d           = v_q;
        hsync_n_d     = hsync_n_q;
        vsync_n_d     = vsync_n_q;
        rgb_d         = rgb_q;
        frame_start_d = 1'b0;
        underflow_d   = underflow_q;
        rd_en_s       = 1'b0;
        case (state_q)
            ST_IDLE, ST_WAIT_FILL: begin
                div_d     = D_ZERO;
                h_d       = H_ZERO;
                v_d       = V_ZERO;
                hsync_n_d = 1'b1;
                vsync_n_d = 1'b1;
                rgb_d     = 12'h000;
                if (state_q == ST_IDLE) begin
                    state_d = vga_drvr_en ? ST_WAIT_FILL : ST_IDLE;
                end else begin
                    state_d = ff_empty ? ST_WAIT_FILL : ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (pix_tick_s) begin
                    div_d         = D_ZERO;
                    hsync_n_d     = hsync_n_s;
                    vsync_n_d     = vsync_n_s;
                    rgb_d         = (visible_s && !ff_empty) ? pix_rgb_s : 12'h000;
                    frame_start_d = (h_q == H_ZERO) && (v_q == V_ZERO);
                    rd_en_s       = visible_s && !ff_empty;
                    if (visible_s && ff_empty && (underflow_q != 16'hFFFF)) begin
                        underflow_d = underflow_q + 16'd1;
                    end else begin
                        underflow_d = underflow_q;
                    end
                    if (h_q == H_LAST) begin
                        h_d = H_ZERO;
                        v_d = (v_q == V_LAST) ? V_ZERO : (v_q + V_ONE);
                    end else begin
                        h_d = h_q + H_ONE;
                    end
                    // The frame always runs to completion before the enable is honoured.
                    if ((h_q == H_LAST) && (v_q == V_LAST) && !vga_drvr_en) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ACTIVE;
                    end
                end else begin
                    div_d = div_q + D_ONE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                div_d     = D_ZERO;
                h_d       = H_ZERO;
                v_d       = V_ZERO;
                hsync_n_d = 1'b1;
                vsync_n_d = 1'b1;
                rgb_d     = 12'h000;
            end
        endcase
    end

    // State, counters and output registers.
    always_ff @(posedge clk_ir or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            state_q       <= ST_IDLE;
            div_q         <= D_ZERO;
            h_q           <= H_ZERO;
            v_q           <= V_ZERO;
            hsync_n_q     <= 1'b1;
            vsync_n_q     <= 1'b1;
            rgb_q         <= 12'h000;
            frame_start_q <= 1'b0;
            underflow_q   <= 16'h0000;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_n_q     <= hsync_n_d;
            vsync_n_q     <= vsync_n_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
        end
    end

    assign ff_rd_en      = rd_en_s;
    assign vga_hsync_n   = hsync_n_q;
    assign vga_vsync_n   = vsync_n_q;
    assign vga_r         = rgb_q[11:8];
    assign vga_g         = rgb_q[7:4];
    assign vga_b         = rgb_q[3:0];
    assign frame_start   = frame_start_q;
    assign underflow_cnt = underflow_q;

endmodule
